// File: rtl/led_hub75_scan_ctrl.sv
// HUB75/HUB75E scan and timing generator: panel clock, latch, OE, row address,
// PWM compare code and AL422 read-pointer rewind, driven by the decoder's pixel strobe.
module led_hub75_scan_ctrl #(
    parameter int unsigned PIXEL_COUNT    = 64,
    parameter int unsigned SCAN_ROWS      = 8,
    parameter int unsigned PWM_BITS       = 8,
    parameter int unsigned OE_PREDELAY    = 2,
    parameter int unsigned OE_POSTDELAY   = 2,
    parameter int unsigned BIT_REVERSE    = 1,
    parameter int unsigned OE_ACTIVE_LOW  = 1,
    parameter int unsigned LAT_ACTIVE_LOW = 0,
    parameter int unsigned CLK_ON_FALL    = 0
) (
    input  logic                in_clk,
    input  logic                in_nrst,
    input  logic                pix_strobe,
    input  logic                enable,
    input  logic [7:0]          brightness,
    output logic                led_clk_out,
    output logic                led_lat_out,
    output logic                led_oe_out,
    output logic [4:0]          led_row,
    output logic [PWM_BITS-1:0] pwm_code,
    output logic                fifo_nrst,
    output logic                frame_start
);

    localparam int unsigned PCW = $clog2(PIXEL_COUNT);
    localparam int unsigned RW  = $clog2(SCAN_ROWS);
    localparam int unsigned OW  = PCW + 1;
    localparam int unsigned PW  = PWM_BITS;
    localparam int unsigned W   = PIXEL_COUNT - OE_PREDELAY - OE_POSTDELAY;

    localparam logic [PCW-1:0] PIX_LAST = PCW'(PIXEL_COUNT - 1);
    localparam logic [PCW-1:0] PIX_INIT = PCW'(PIXEL_COUNT - 2);
    localparam logic [PCW-1:0] PIX_FIFO = PCW'(PIXEL_COUNT - 3);
    localparam logic [RW-1:0]  ROW_LAST = RW'(SCAN_ROWS - 1);
    localparam logic [RW-1:0]  ROW_INIT = RW'(SCAN_ROWS - 2);
    localparam logic [PW-1:0]  PWM_MAX  = PW'((2 ** PW) - 2);
    localparam logic [OW-1:0]  OE_ON    = OW'(OE_POSTDELAY);
    localparam logic [OW-1:0]  ON_FULL  = OW'(W);

    logic [PCW-1:0] r_pixel_cnt;
    logic [RW-1:0]  r_row;
    logic [PW-1:0]  r_pwm_cnt;
    logic [7:0]     r_b_q;
    logic [OW-1:0]  r_on_len;
    logic           r_clk;
    logic           r_lat;
    logic           r_oe;
    logic           r_fifo_nrst;
    logic           r_frame_start;

    logic           w_lat;
    logic           w_frame;
    logic           w_fifo_rewind;
    logic [PCW-1:0] w_pix_next;
    logic [OW-1:0]  w_pix_next_ext;
    logic [RW-1:0]  w_row_next;
    logic [PW-1:0]  w_pwm_next;
    logic [OW-1:0]  w_on_end;
    logic [19:0]    w_prod;
    logic [OW-1:0]  w_on_len_calc;
    logic [PW-1:0]  w_pwm_rev;

    assign w_lat          = pix_strobe && (r_pixel_cnt == PIX_LAST);
    assign w_frame        = w_lat && (r_row == ROW_LAST);
    assign w_fifo_rewind  = pix_strobe && (r_pixel_cnt == PIX_FIFO) && (r_row == ROW_LAST);
    assign w_pix_next     = (r_pixel_cnt == PIX_LAST) ? '0 : r_pixel_cnt + PCW'(1);
    assign w_pix_next_ext = OW'(w_pix_next);
    assign w_row_next     = (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
    assign w_pwm_next     = (r_pwm_cnt == PWM_MAX) ? '0 : r_pwm_cnt + PW'(1);
    assign w_on_end       = OE_ON + r_on_len;
    assign w_prod         = 20'(W) * (20'(r_b_q) + 20'd1);
    assign w_on_len_calc  = OW'(w_prod[19:8]);

    // Bit-reversed PWM counter spreads on-time across frames (dithered PWM)
    always_comb begin
        w_pwm_rev = '0;
        for (int i = 0; i < int'(PW); i++) begin
            w_pwm_rev[i] = r_pwm_cnt[PW-1-i];
        end
    end

    // Pixel and row counters; start two pixels early because the decoder prefetches
    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            r_pixel_cnt <= PIX_INIT;
            r_row       <= ROW_INIT;
        end else if (pix_strobe) begin
            r_pixel_cnt <= w_pix_next;
            if (w_lat) begin
                r_row <= w_row_next;
            end
        end
    end

    // Per-frame state: PWM step, brightness capture, OE window length
    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            r_pwm_cnt <= PWM_MAX;
            r_b_q     <= 8'hFF;
            r_on_len  <= ON_FULL;
        end else begin
            if (w_frame) begin
                r_pwm_cnt <= w_pwm_next;
                r_b_q     <= brightness;
            end
            r_on_len <= w_on_len_calc;
        end
    end

    // Single-cycle strobes: shift clock, latch, frame marker and FIFO rewind
    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            r_clk         <= 1'b0;
            r_lat         <= 1'b0;
            r_frame_start <= 1'b0;
            r_fifo_nrst   <= 1'b1;
        end else begin
            r_clk         <= pix_strobe;
            r_lat         <= w_lat;
            r_frame_start <= w_frame;
            r_fifo_nrst   <= !w_fifo_rewind;
        end
    end

    // OE window: opens at the post-latch guard, closes after on_len pixels or on blanking
    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            r_oe <= 1'b0;
        end else if (!enable) begin
            r_oe <= 1'b0;
        end else if (pix_strobe) begin
            if ((w_pix_next_ext == OE_ON) && (r_on_len != '0)) begin
                r_oe <= 1'b1;
            end else if (w_pix_next_ext == w_on_end) begin
                r_oe <= 1'b0;
            end
        end
    end

    assign led_clk_out = r_clk ^ (CLK_ON_FALL != 0);
    assign led_lat_out = r_lat ^ (LAT_ACTIVE_LOW != 0);
    assign led_oe_out  = r_oe ^ (OE_ACTIVE_LOW != 0);
    assign led_row     = 5'(r_row);
    assign pwm_code    = (BIT_REVERSE != 0) ? w_pwm_rev : r_pwm_cnt;
    assign fifo_nrst   = r_fifo_nrst;
    assign frame_start = r_frame_start;

endmodule
